clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
Multi-channel, runtime-programmable integer clock divider. Generates, per channel, a registered divided level and a one-cycle tick (clock-enable) from the single system clock. Divisor and enable are programmable per channel, and all changes apply glitch-free at period boundaries. It replaces fixed compile-time dividers for peripheral timing (UART baud, LED/display scan, PWM bases) on the Nexys4DDR SoC fabric.

Parameters:
CH, 4, number of independent divider channels (1..16)
CNT_W, 16, divisor/counter width; maximum divisor 2^CNT_W-1
CH_W, $clog2(CH) (minimum 1), channel-select width (derived, not overridden)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe for channel configuration
wr_ch  in  CH_W  target channel; values >= CH are ignored
wr_div  in  CNT_W  divisor N
wr_ena  in  1  channel enable
sync_all  in  1  restart all running channels in phase
clk_out  out  CH  divided level per channel (registered)
tick  out  CH  one-cycle pulse at start of each period (registered)
running  out  CH  channel active
pending  out  CH  written config not yet applied

Behaviour:
- Reset (rst=1 at edge): all cnt=0, div_cur=0, en_cur=0, pending=0; clk_out=0, tick=0, running=0. Reset overrides wr_en and sync_all.
- Per channel: active divisor div_cur, counter cnt (CNT_W), pending register {div_pend, ena_pend}. HI = ceil(div_cur/2).
- A write to a channel stores {wr_div, wr_ena} in the pending register and sets pending. Last write wins when the channel is already pending. wr_div=0 is treated as wr_ena=0.
- Stopped channel with pending set: config applies at the same edge. If ena=1, then running=1, cnt=0, tick=1, clk_out=1 from that edge; pending clears. If ena=0, only the config is stored and outputs stay low.
- Running channel, at each edge:
  - If cnt==div_cur-1 (period boundary): cnt<=0; apply pending if set; if still enabled then tick<=1, clk_out<=1; else running<=0, tick<=0, clk_out<=0.
  - Otherwise: cnt<=cnt+1, tick<=0, clk_out<=(cnt+1 < HI).
- Waveform: period = N cycles; high for ceil(N/2), low for floor(N/2). Even N gives 50% duty; odd N is high one cycle longer. Single-edge only; no negedge logic.
- N=1: tick=1 every cycle; clk_out held 1.
- Disable never truncates: the current period completes, then the outputs go low.
- sync_all at edge: first latch any same-cycle write into pending, then apply all pending configs. Every channel enabled after that restarts with cnt=0, tick=1, clk_out=1. Channels ending disabled stop immediately with outputs low. Phase truncation from sync_all is permitted.
- Ignored write (wr_ch >= CH): no state change.
- Counter arithmetic is CNT_W wide and never exceeds div_cur-1. A divisor change applies only at cnt=0, so there is no wrap hazard.

Test Plan:
- Reset: hold rst 3 cycles with wr_en=1 and sync_all=1 -> all outputs 0 and pending=0 after release.
- Even divisor: write ch0 N=4, ena=1 -> tick every 4 cycles starting the edge after the write; clk_out pattern 1100 repeating.
- Odd divisor: write ch1 N=5 -> clk_out pattern 11100, tick at each first 1. Then write N=1 -> after the current period completes, tick and clk_out are constant 1.
- Mid-period change: ch0 running N=6; write N=3 at cnt=2 -> pending=1; the old period finishes (6 cycles total), then the 110 pattern starts; pending clears at the boundary edge.
- Disable and sync: ch0 N=4, ch1 N=6 running. Write ch0 ena=0 mid-period -> ch0 finishes its period, then stays low. Write ch0 N=4 ena=1 and assert sync_all in the same cycle -> both channels tick on the same edge, then at 4- and 6-cycle periods.
- Boundaries: write wr_div=0, ena=1 to a stopped channel -> stays stopped. Write to wr_ch=CH (when CH is not a power of 2) -> no change. Two writes to a pending channel -> the second value is the one applied.

Source files
------------

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable integer clock divider: each channel makes a registered divided level
// and a one-cycle tick. New configurations take effect only at period boundaries or on sync_all.
module clkdiv_multi #(
  parameter int CH    = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_ena,
  input  logic             sync_all,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    running,
  output logic [CH-1:0]    pending
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W = (CNT_W+1)'(1);

  // Write interface: wr_en is a single-cycle strobe with no back-pressure. Each cycle it is high,
  // {wr_div, wr_ena} is taken by channel wr_ch. If wr_ch has no matching channel, the write is dropped.
  for (genvar g = 0; g < CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(g);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_ena_pend;
    logic             r_pending;
    logic             r_running;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_hit;
    logic             w_pend_v;
    logic             w_pena;
    logic             w_boundary;
    logic             w_end;
    logic             w_en_next;
    logic [CNT_W-1:0] w_pdiv;
    logic [CNT_W:0]   w_hi;
    logic [CNT_W:0]   w_cnt_inc;

    // A same-cycle write is folded into the pending view first, so it can apply on this edge.
    assign w_hit      = wr_en && (wr_ch == IDX);
    assign w_pend_v   = w_hit || r_pending;
    assign w_pdiv     = w_hit ? wr_div : r_div_pend;
    assign w_pena     = w_hit ? (wr_ena && (wr_div != '0)) : r_ena_pend;
    assign w_boundary = r_running && (r_cnt == (r_div_cur - ONE));
    assign w_end      = sync_all || !r_running || w_boundary;
    assign w_en_next  = w_pend_v ? w_pena : r_running;
    assign w_hi       = ({1'b0, r_div_cur} + ONE_W) >> 1;
    assign w_cnt_inc  = {1'b0, r_cnt} + ONE_W;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt      <= '0;
        r_div_cur  <= '0;
        r_div_pend <= '0;
        r_ena_pend <= 1'b0;
        r_pending  <= 1'b0;
        r_running  <= 1'b0;
        r_clk_out  <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        r_div_pend <= w_pdiv;
        r_ena_pend <= w_pena;
        if (w_end) begin
          // Period start, stopped channel, or forced restart: commit any pending config here.
          r_cnt     <= '0;
          r_pending <= 1'b0;
          r_running <= w_en_next;
          r_tick    <= w_en_next;
          r_clk_out <= w_en_next;
          if (w_pend_v) begin
            r_div_cur <= w_pdiv;
          end
        end else begin
          r_cnt     <= w_cnt_inc[CNT_W-1:0];
          r_pending <= w_pend_v;
          r_tick    <= 1'b0;
          r_clk_out <= (w_cnt_inc < w_hi);
        end
      end
    end

    assign clk_out[g] = r_clk_out;
    assign tick[g]    = r_tick;
    assign running[g] = r_running;
    assign pending[g] = r_pending;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: per-channel period/phase model checked every cycle, directed scenarios
// pinned with literal waveforms, then randomized writes, syncs and resets.
module tb_clkdiv_multi;
  localparam int CH    = 5;
  localparam int CNT_W = 16;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_ena;
  logic             sync_all;
  logic [CH-1:0]    clk_out, tick, running, pending;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;

  // model: position within the current period and the divisor of that period
  int  m_phase [CH];
  int  m_n     [CH];
  int  m_pn    [CH];
  bit  m_run   [CH];
  bit  m_pend  [CH];
  bit  m_pe    [CH];

  clkdiv_multi #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .wr_ena(wr_ena), .sync_all(sync_all), .clk_out(clk_out), .tick(tick),
    .running(running), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_phase[c] = 0; m_n[c] = 0; m_pn[c] = 0;
        m_run[c] = 0; m_pend[c] = 0; m_pe[c] = 0;
      end else begin
        if (wr_en && int'(wr_ch) == c) begin
          m_pend[c] = 1;
          m_pn[c]   = int'(wr_div);
          m_pe[c]   = wr_ena && (wr_div != 0);
        end
        if (sync_all || !m_run[c] || m_phase[c] + 1 >= m_n[c]) begin
          if (m_pend[c]) begin
            m_run[c]  = m_pe[c];
            m_n[c]    = m_pn[c];
            m_pend[c] = 0;
          end
          m_phase[c] = 0;
        end else begin
          m_phase[c]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [CH-1:0] e_t, e_c, e_r, e_p;
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        e_r[c] = m_run[c];
        e_p[c] = m_pend[c];
        e_t[c] = m_run[c] && m_phase[c] == 0;
        e_c[c] = m_run[c] && m_phase[c] < (m_n[c] + 1) / 2;
      end
      check_lit("model_tick", 32'(tick), 32'(e_t));
      check_lit("model_clk_out", 32'(clk_out), 32'(e_c));
      check_lit("model_running", 32'(running), 32'(e_r));
      check_lit("model_pending", 32'(pending), 32'(e_p));
    end
  end

  task automatic do_write(input int ch, input int div, input bit ena, input bit sync);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = CNT_W'(div); wr_ena = ena; sync_all = sync;
    @(negedge clk);
    wr_en = 1'b0; sync_all = 1'b0;
  endtask

  task automatic wait_pend_clear(input int ch, input string name);
    for (int k = 0; k < 24 && pending[ch]; k++) @(negedge clk);
    check_lit(name, 32'(pending[ch]), 32'd0);
  endtask

  initial begin
    logic [7:0] pt, pc;
    logic [9:0] ot, oc;
    rst = 1'b1; wr_en = 1'b1; wr_ch = '0; wr_div = 16'd4; wr_ena = 1'b1; sync_all = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; sync_all = 1'b0;
    chk_en = 1'b1;
    check_lit("reset_clk_out", 32'(clk_out), 32'd0);
    check_lit("reset_tick", 32'(tick), 32'd0);
    check_lit("reset_running", 32'(running), 32'd0);
    check_lit("reset_pending", 32'(pending), 32'd0);

    // even divisor on ch0
    do_write(0, 4, 1'b1, 1'b0);
    pt = 8'b1000_1000; pc = 8'b1100_1100;
    for (int i = 0; i < 8; i++) begin
      check_lit("even_tick", 32'(tick[0]), 32'(pt[7-i]));
      check_lit("even_clk", 32'(clk_out[0]), 32'(pc[7-i]));
      @(negedge clk);
    end

    // odd divisor on ch1, then N=1 after the period finishes
    do_write(1, 5, 1'b1, 1'b0);
    ot = 10'b10000_10000; oc = 10'b11100_11100;
    for (int i = 0; i < 10; i++) begin
      check_lit("odd_tick", 32'(tick[1]), 32'(ot[9-i]));
      check_lit("odd_clk", 32'(clk_out[1]), 32'(oc[9-i]));
      @(negedge clk);
    end
    do_write(1, 1, 1'b1, 1'b0);
    wait_pend_clear(1, "n1_pend_clear");
    for (int i = 0; i < 3; i++) begin
      check_lit("n1_tick", 32'(tick[1]), 32'd1);
      check_lit("n1_clk", 32'(clk_out[1]), 32'd1);
      @(negedge clk);
    end

    // mid-period divisor change on ch0
    do_write(0, 6, 1'b1, 1'b0);
    wait_pend_clear(0, "n6_pend_clear");
    check_lit("n6_start_tick", 32'(tick[0]), 32'd1);
    repeat (2) @(negedge clk);
    do_write(0, 3, 1'b1, 1'b0);
    check_lit("mid_pend_set", 32'(pending[0]), 32'd1);
    @(negedge clk);
    check_lit("mid_ph4_clk", 32'(clk_out[0]), 32'd0);
    check_lit("mid_ph4_pend", 32'(pending[0]), 32'd1);
    @(negedge clk);
    check_lit("mid_ph5_tick", 32'(tick[0]), 32'd0);
    @(negedge clk);
    check_lit("mid_bound_tick", 32'(tick[0]), 32'd1);
    check_lit("mid_bound_pend", 32'(pending[0]), 32'd0);
    @(negedge clk);
    check_lit("n3_ph1_clk", 32'(clk_out[0]), 32'd1);
    @(negedge clk);
    check_lit("n3_ph2_clk", 32'(clk_out[0]), 32'd0);
    @(negedge clk);
    check_lit("n3_next_tick", 32'(tick[0]), 32'd1);

    // disable without truncation, then sync restart
    do_write(1, 6, 1'b1, 1'b0);
    do_write(0, 4, 1'b1, 1'b0);
    wait_pend_clear(0, "dis_pend_clear");
    @(negedge clk);
    do_write(0, 4, 1'b0, 1'b0);
    check_lit("dis_ph2_run", 32'(running[0]), 32'd1);
    @(negedge clk);
    check_lit("dis_ph3_run", 32'(running[0]), 32'd1);
    @(negedge clk);
    check_lit("dis_stop_run", 32'(running[0]), 32'd0);
    check_lit("dis_stop_clk", 32'(clk_out[0]), 32'd0);
    check_lit("dis_stop_tick", 32'(tick[0]), 32'd0);
    do_write(0, 4, 1'b1, 1'b1);
    check_lit("sync_tick", 32'(tick), 32'b00011);
    repeat (4) @(negedge clk);
    check_lit("sync_t4", 32'(tick[1:0]), 32'b01);
    repeat (2) @(negedge clk);
    check_lit("sync_t6", 32'(tick[1:0]), 32'b10);

    // boundaries: zero divisor, out-of-range channel, last write wins
    do_write(2, 0, 1'b1, 1'b0);
    check_lit("div0_run", 32'(running[2]), 32'd0);
    check_lit("div0_pend", 32'(pending[2]), 32'd0);
    do_write(5, 3, 1'b1, 1'b0);
    do_write(7, 2, 1'b1, 1'b0);
    check_lit("oor_pend", 32'(pending), 32'd0);
    check_lit("oor_run", 32'(running[4:2]), 32'd0);
    do_write(0, 7, 1'b1, 1'b0);
    do_write(0, 2, 1'b1, 1'b0);
    wait_pend_clear(0, "lww_pend_clear");
    check_lit("lww_tick0", 32'(tick[0]), 32'd1);
    @(negedge clk);
    check_lit("lww_tick1", 32'(tick[0]), 32'd0);
    @(negedge clk);
    check_lit("lww_tick2", 32'(tick[0]), 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom_range(0, 5) == 0);
      wr_ch    = CH_W'($urandom_range(0, 7));
      wr_div   = CNT_W'(($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 11));
      wr_ena   = ($urandom_range(0, 4) != 0);
      sync_all = ($urandom_range(0, 60) == 0);
      rst      = ($urandom_range(0, 700) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0; sync_all = 1'b0; rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
